// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the writeback sources and the
// register-file write arbiter.
//   REG_ADDR_W / REG_DATA_W : architectural register address / data widths
//   REG_ZERO                : address of the hardwired zero register
//   wb_req_t                : one writeback request (destination + value)
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter with a registered priority pointer.
//   clk       : clock, pointer updates on posedge
//   rst       : asynchronous active-high reset (pointer -> 0)
//   req       : per-requester request vector
//   advance   : a grant was consumed this cycle; pointer moves past the winner
//   grant     : one-hot grant (combinational), subset of req
//   grant_idx : index of the granted requester (0 when nothing is granted)
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] rr_ptr;

    // Search starts at rr_ptr and wraps; N need not be a power of two,
    // so the wrap is an explicit subtract rather than a bit truncation.
    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between NUM_REQ writeback
// sources (ALU, load, mul/div) using round-robin arbitration, and holds the
// winning write in one registered stage that drives the port directly.
//   clk, rst      : clock / asynchronous active-high reset
//   req_valid     : per-requester write request
//   req_addr      : packed destinations, requester i at [i*ADDR_W +: ADDR_W]
//   req_data      : packed write data, requester i at [i*DATA_W +: DATA_W]
//   req_ready     : one-hot grant; transfer when req_valid[i] && req_ready[i]
//   hold          : freezes arbitration (exception / flush sequencing)
//   RegWrite      : register-file write enable
//   Wreg, Wdata   : register-file write address / data
//   fwd_valid     : in-flight write visible to the forwarding unit
//   grant_id      : requester that owns the output stage
//   conflict_cnt  : saturating count of cycles with >1 valid request
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        hold,
    output logic                        RegWrite,
    output logic [ADDR_W-1:0]           Wreg,
    output logic [DATA_W-1:0]           Wdata,
    output logic                        fwd_valid,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic [CNT_W-1:0]            conflict_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] arb_req_p0;
    logic [IDX_W-1:0]   arb_idx_p0;
    logic               vld_p0;
    logic [ADDR_W-1:0]  sel_addr_p0;
    logic [DATA_W-1:0]  sel_data_p0;
    logic [IDX_W:0]     nvalid_p0;
    logic               conflict_p0;

    logic               vld_p1;
    logic [ADDR_W-1:0]  wreg_p1;
    logic [DATA_W-1:0]  wdata_p1;
    logic [IDX_W-1:0]   grant_id_p1;
    logic [CNT_W-1:0]   conflict_cnt_p1;

    // ---- stage p0: arbitration and request selection (combinational) ----
    // Masking with rst keeps req_ready low while reset is held.
    assign arb_req_p0 = (rst || hold) ? '0 : req_valid;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req       (arb_req_p0),
        .advance   (vld_p0),
        .grant     (req_ready),
        .grant_idx (arb_idx_p0)
    );

    assign vld_p0 = |req_ready;

    always_comb begin
        sel_addr_p0 = '0;
        sel_data_p0 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_addr_p0 = req_addr[i*ADDR_W +: ADDR_W];
                sel_data_p0 = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Conflicts are counted on raw requests, independent of hold.
    always_comb begin
        nvalid_p0 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            nvalid_p0 = nvalid_p0 + (IDX_W + 1)'(req_valid[i]);
        end
    end

    assign conflict_p0 = (nvalid_p0 > (IDX_W + 1)'(1));

    // ---- stage p1: registered register-file write port ----
    // A request to the zero register is consumed but never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            wreg_p1     <= '0;
            wdata_p1    <= '0;
            grant_id_p1 <= '0;
        end else if (vld_p0) begin
            vld_p1      <= (sel_addr_p0 != ADDR_W'(REG_ZERO));
            wreg_p1     <= sel_addr_p0;
            wdata_p1    <= sel_data_p0;
            grant_id_p1 <= arb_idx_p0;
        end else begin
            vld_p1      <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt_p1 <= '0;
        end else if (conflict_p0 && (conflict_cnt_p1 != '1)) begin
            conflict_cnt_p1 <= conflict_cnt_p1 + 1'b1;
        end
    end

    assign RegWrite     = vld_p1;
    assign fwd_valid    = vld_p1;
    assign Wreg         = wreg_p1;
    assign Wdata        = wdata_p1;
    assign grant_id     = grant_id_p1;
    assign conflict_cnt = conflict_cnt_p1;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    localparam int N     = 3;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            hold;
    logic            RegWrite;
    logic [AW-1:0]   Wreg;
    logic [DW-1:0]   Wdata;
    logic            fwd_valid;
    logic [1:0]      grant_id;
    logic [CW-1:0]   conflict_cnt;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] rf [32];

    // model state
    int            m_ptr = 0;
    bit            m_we  = 0;
    int            m_wreg = 0;
    logic [DW-1:0] m_wdata = '0;
    int            m_gid = 0;
    int            m_cnt = 0;

    regfile_write_arbiter #(
        .NUM_REQ (N), .ADDR_W (AW), .DATA_W (DW), .CNT_W (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .hold         (hold),
        .RegWrite     (RegWrite),
        .Wreg         (Wreg),
        .Wdata        (Wdata),
        .fwd_valid    (fwd_valid),
        .grant_id     (grant_id),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // First valid requester searching from the model pointer, or -1.
    function automatic int pick();
        if (rst || hold) return -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr = 0; m_we = 0; m_wreg = 0; m_wdata = '0; m_gid = 0; m_cnt = 0;
        end else begin
            int g;
            g = pick();
            if ($countones(req_valid) > 1 && m_cnt < CMAX) m_cnt++;
            if (g >= 0) begin
                m_wreg  = int'(req_addr[g*AW +: AW]);
                m_wdata = req_data[g*DW +: DW];
                m_we    = (m_wreg != 0);
                m_gid   = g;
                m_ptr   = (g + 1) % N;
            end else begin
                m_we = 0;
            end
        end
    end

    // Per-cycle comparison, then the register file commits on the negedge.
    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_rdy;
        g = pick();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("RegWrite", 64'(RegWrite), 64'(m_we));
        chk("fwd_valid", 64'(fwd_valid), 64'(m_we));
        chk("Wreg", 64'(Wreg), 64'(m_wreg));
        chk("Wdata", 64'(Wdata), 64'(m_wdata));
        chk("grant_id", 64'(grant_id), 64'(m_gid));
        chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
        if (RegWrite) rf[Wreg] = Wdata;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input logic [N-1:0] v,
                           input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                           input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                           input logic [AW-1:0] a2, input logic [DW-1:0] d2);
        req_valid = v;
        req_addr  = {a2, a1, a0};
        req_data  = {d2, d1, d0};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rst = 1'b0;
        hold = 1'b0;
        set_req(3'b111, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h3);
        #1 rst = 1'b1;

        // reset state, with requests pending
        step();
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_regwrite", 64'(RegWrite), 64'h0);
        chk("rst_cnt", 64'(conflict_cnt), 64'h0);
        chk("rst_gid", 64'(grant_id), 64'h0);
        set_req(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        rst = 1'b0;
        step();

        // single write
        set_req(3'b001, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd0, 32'h0);
        #1 chk("single_ready", 64'(req_ready), 64'h1);
        step();
        chk("single_we", 64'(RegWrite), 64'h1);
        chk("single_wreg", 64'(Wreg), 64'd5);
        chk("single_wdata", 64'(Wdata), 64'hDEADBEEF);
        chk("single_gid", 64'(grant_id), 64'h0);
        chk("single_rf5", 64'(rf[5]), 64'hDEADBEEF);
        req_valid = '0;
        step();
        chk("idle_we", 64'(RegWrite), 64'h0);
        chk("idle_wreg_held", 64'(Wreg), 64'd5);

        // fairness + conflict counter saturation
        do_reset();
        set_req(3'b111, 5'd1, 32'hA1, 5'd2, 32'hA2, 5'd3, 32'hA3);
        for (int i = 0; i < 18; i++) begin
            step();
            chk("fair_gid", 64'(grant_id), 64'(i % 3));
            chk("fair_we", 64'(RegWrite), 64'h1);
            chk("fair_cnt", 64'(conflict_cnt), 64'((i + 1 > 15) ? 15 : i + 1));
        end
        req_valid = '0;
        step();
        chk("fair_rf3", 64'(rf[3]), 64'hA3);
        chk("sat_cnt", 64'(conflict_cnt), 64'd15);

        // register zero: consumed, not written, pointer advances to 2
        set_req(3'b010, 5'd0, 32'h0, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0);
        #1 chk("zero_ready", 64'(req_ready), 64'h2);
        step();
        chk("zero_we", 64'(RegWrite), 64'h0);
        chk("zero_rf0", 64'(rf[0]), 64'h0);
        set_req(3'b111, 5'd1, 32'hB1, 5'd2, 32'hB2, 5'd3, 32'hB3);
        #1 chk("zero_ptr2", 64'(req_ready), 64'h4);
        req_valid = '0;

        // same-destination collision
        do_reset();
        set_req(3'b101, 5'd7, 32'h11, 5'd0, 32'h0, 5'd7, 32'h22);
        #1 chk("coll_ready", 64'(req_ready), 64'h1);
        step();
        chk("coll_gid0", 64'(grant_id), 64'h0);
        chk("coll_wdata0", 64'(Wdata), 64'h11);
        req_valid = 3'b100;
        step();
        chk("coll_gid2", 64'(grant_id), 64'h2);
        chk("coll_wdata2", 64'(Wdata), 64'h22);
        req_valid = '0;
        step();
        chk("coll_rf7", 64'(rf[7]), 64'h22);

        // hold: in-flight write completes, no grants, pointer frozen at 1
        set_req(3'b111, 5'd1, 32'hC1, 5'd2, 32'hC2, 5'd3, 32'hC3);
        step();
        chk("pre_hold_gid", 64'(grant_id), 64'h0);
        hold = 1'b1;
        #1 chk("hold_ready0", 64'(req_ready), 64'h0);
        chk("hold_inflight_we", 64'(RegWrite), 64'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold_ready", 64'(req_ready), 64'h0);
            chk("hold_we", 64'(RegWrite), 64'h0);
        end
        hold = 1'b0;
        #1 chk("hold_release", 64'(req_ready), 64'h2);
        step();
        chk("hold_release_gid", 64'(grant_id), 64'h1);
        req_valid = '0;
        step();

        // async reset mid-operation drops the pending write
        set_req(3'b001, 5'd9, 32'h55, 5'd0, 32'h0, 5'd0, 32'h0);
        step();
        req_valid = '0;
        step();
        chk("pre_rf9", 64'(rf[9]), 64'h55);
        set_req(3'b011, 5'd9, 32'hAA, 5'd4, 32'h44, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 3'b010;
        chk("mid_we", 64'(RegWrite), 64'h1);
        chk("mid_cnt_nz", 64'(conflict_cnt != 0), 64'h1);
        #1 rst = 1'b1;
        #1;
        chk("arst_we", 64'(RegWrite), 64'h0);
        chk("arst_cnt", 64'(conflict_cnt), 64'h0);
        chk("arst_ready", 64'(req_ready), 64'h0);
        step();
        rst = 1'b0;
        chk("arst_rf9", 64'(rf[9]), 64'h55);
        #1 chk("arst_pending", 64'(req_ready), 64'h2);
        req_valid = '0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
